// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM state encoding, operator
// codes and the operand magnitude limit derived from the digit count.
package calc_pkg;

  localparam int MAX_DIGITS_DEF = 32'sd4;
  localparam int MAG_W_DEF      = 32'sd14;

  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_OP  = 3'd1,
    S_B   = 3'd2,
    S_RES = 3'd3,
    S_ERR = 3'd4
  } state_t;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  // Largest magnitude representable with the given number of decimal digits.
  function automatic int unsigned max_mag(input int unsigned digits);
    int unsigned v;
    v = 32'd1;
    for (int unsigned i = 32'd0; i < digits; i++) begin
      v = v * 32'd10;
    end
    return v - 32'd1;
  endfunction

  localparam int unsigned LIMIT_DEF = max_mag(MAX_DIGITS_DEF);

endpackage

// File: rtl/calc_if.sv
// Keypad-side and display-side signal bundle of the calculator sequencer.
// The master side is the scanner/display environment, the slave side is calc_ctrl.
interface calc_if
  import calc_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF
);
  logic             btn_press;
  logic             is_num;
  logic             is_op;
  logic             is_eq;
  logic [3:0]       num_val;
  logic [1:0]       op_val;
  logic [MAG_W-1:0] disp_mag;
  logic             disp_neg;
  logic             disp_err;
  logic [1:0]       cur_op;
  logic [2:0]       state_o;

  modport master (
    output btn_press, is_num, is_op, is_eq, num_val, op_val,
    input  disp_mag, disp_neg, disp_err, cur_op, state_o
  );

  modport slave (
    input  btn_press, is_num, is_op, is_eq, num_val, op_val,
    output disp_mag, disp_neg, disp_err, cur_op, state_o
  );
endinterface

// File: rtl/calc_alu.sv
// Combinational operator unit: A (signed) op B (unsigned) with overflow check.
// Build option: CALC_MUL_EN enables the multiply operator (op code 3).
module calc_alu
  import calc_pkg::*;
#(
  parameter int          MAG_W = MAG_W_DEF,
  parameter int unsigned LIMIT = LIMIT_DEF
) (
  input  logic signed [MAG_W:0]   a,
  input  logic        [MAG_W-1:0] b,
  input  logic        [1:0]       op,
  input  logic        [1:0]       key_op,
  output logic signed [MAG_W:0]   res,
  output logic                    ovf,
  output logic                    key_op_ok
);

`ifdef CALC_MUL_EN
  localparam int W = 2 * MAG_W + 32'sd1;
`else
  localparam int W = MAG_W + 32'sd2;
`endif

  localparam logic signed [W-1:0] LIM = W'(LIMIT);

  logic signed [W-1:0] a_w;
  logic signed [W-1:0] b_w;
  logic signed [W-1:0] full;

  // Full-width arithmetic; res carries the accumulator-width slice, valid when !ovf.
  always_comb begin
    a_w  = W'(a);
    b_w  = W'({1'b0, b});
    full = a_w;
    case (op)
      OP_ADD:  full = a_w + b_w;
      OP_SUB:  full = a_w - b_w;
`ifdef CALC_MUL_EN
      OP_MUL:  full = a_w * b_w;
`endif
      default: full = a_w;
    endcase
    ovf = (full > LIM) || (full < -LIM);
    res = full[MAG_W:0];
  end

  // Operator keys this build understands; anything else is dropped by the FSM.
  always_comb begin
    key_op_ok = 1'b0;
    case (key_op)
      OP_ADD, OP_SUB: key_op_ok = 1'b1;
`ifdef CALC_MUL_EN
      OP_MUL:         key_op_ok = 1'b1;
`endif
      default:        key_op_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: key edge detection, operand entry, operator chaining
// and display drive. Build option: CALC_MUL_EN (multiply, handled in calc_alu).
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF,
  parameter int MAG_W      = MAG_W_DEF
) (
  input  logic clk,
  input  logic rst,
  calc_if.slave bus
);

  localparam int unsigned LIMIT = max_mag(MAX_DIGITS);
  localparam int          CNT_W = $clog2(MAX_DIGITS + 32'sd1);
  localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic signed [MAG_W:0]   TEN_A   = (MAG_W + 1)'(10);
  localparam logic        [MAG_W-1:0] TEN_B   = MAG_W'(10);

  state_t                  state_q, state_d;
  logic signed [MAG_W:0]   a_q, a_d;
  logic        [MAG_W-1:0] b_q, b_d;
  logic        [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic        [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic        [1:0]       op_q, op_d;
  logic                    btn_press_q;
  logic        [MAG_W-1:0] disp_mag_q, disp_mag_d;
  logic                    disp_neg_q, disp_neg_d;
  logic                    disp_err_q, disp_err_d;

  logic                    key_evt, num_evt, op_evt, eq_evt;
  logic                    key_op_ok;
  logic signed [MAG_W:0]   dig_a;
  logic        [MAG_W-1:0] dig_b;
  logic signed [MAG_W:0]   alu_res;
  logic                    alu_ovf;

  calc_alu #(
    .MAG_W (MAG_W),
    .LIMIT (LIMIT)
  ) u_alu (
    .a         (a_q),
    .b         (b_q),
    .op        (op_q),
    .key_op    (bus.op_val),
    .res       (alu_res),
    .ovf       (alu_ovf),
    .key_op_ok (key_op_ok)
  );

  // One event per press; class priority num > op > eq.
  always_comb begin
    key_evt = bus.btn_press & ~btn_press_q;
    num_evt = key_evt & bus.is_num;
    op_evt  = key_evt & ~bus.is_num & bus.is_op & key_op_ok;
    eq_evt  = key_evt & ~bus.is_num & ~bus.is_op & bus.is_eq;
    dig_a   = {{(MAG_W - 3){1'b0}}, bus.num_val};
    dig_b   = {{(MAG_W - 4){1'b0}}, bus.num_val};
  end

  // Next-state and operand/operator register updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    op_d    = op_q;
    case (state_q)
      S_A: begin
        if (num_evt) begin
          if (a_cnt_q < CNT_MAX) begin
            a_d     = a_q * TEN_A + dig_a;
            a_cnt_d = a_cnt_q + CNT_ONE;
          end else begin
            a_d = a_q;
          end
        end else if (op_evt) begin
          op_d    = bus.op_val;
          state_d = S_OP;
        end else begin
          state_d = S_A;
        end
      end
      S_OP: begin
        if (num_evt) begin
          b_d     = dig_b;
          b_cnt_d = CNT_ONE;
          state_d = S_B;
        end else if (op_evt) begin
          op_d = bus.op_val;
        end else begin
          state_d = S_OP;
        end
      end
      S_B: begin
        if (num_evt) begin
          if (b_cnt_q < CNT_MAX) begin
            b_d     = b_q * TEN_B + dig_b;
            b_cnt_d = b_cnt_q + CNT_ONE;
          end else begin
            b_d = b_q;
          end
        end else if (op_evt || eq_evt) begin
          // An overflowing compute wipes both operands and the pending operator.
          if (alu_ovf) begin
            a_d     = '0;
            b_d     = '0;
            a_cnt_d = '0;
            b_cnt_d = '0;
            op_d    = OP_NONE;
            state_d = S_ERR;
          end else begin
            a_d     = alu_res;
            op_d    = op_evt ? bus.op_val : OP_NONE;
            state_d = op_evt ? S_OP : S_RES;
          end
        end else begin
          state_d = S_B;
        end
      end
      S_RES: begin
        if (num_evt) begin
          a_d     = dig_a;
          a_cnt_d = CNT_ONE;
          state_d = S_A;
        end else if (op_evt) begin
          op_d    = bus.op_val;
          state_d = S_OP;
        end else begin
          state_d = S_RES;
        end
      end
      S_ERR: begin
        if (num_evt) begin
          a_d     = dig_a;
          a_cnt_d = CNT_ONE;
          state_d = S_A;
        end else begin
          state_d = S_ERR;
        end
      end
      default: begin
        state_d = S_A;
        a_d     = '0;
        b_d     = '0;
        a_cnt_d = '0;
        b_cnt_d = '0;
        op_d    = OP_NONE;
      end
    endcase
  end

  // Display values are derived from next-state so the registered outputs track the FSM.
  always_comb begin
    disp_mag_d = '0;
    disp_neg_d = 1'b0;
    disp_err_d = 1'b0;
    case (state_d)
      S_B: begin
        disp_mag_d = b_d;
      end
      S_ERR: begin
        disp_err_d = 1'b1;
      end
      S_A, S_OP, S_RES: begin
        if (a_d[MAG_W]) begin
          disp_mag_d = MAG_W'(-a_d);
          disp_neg_d = 1'b1;
        end else begin
          disp_mag_d = MAG_W'(a_d);
          disp_neg_d = 1'b0;
        end
      end
      default: begin
        disp_mag_d = '0;
      end
    endcase
  end

  // State and output registers; the edge detector reloads from the key during
  // reset so a key held through reset never produces an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      a_cnt_q     <= '0;
      b_cnt_q     <= '0;
      op_q        <= OP_NONE;
      btn_press_q <= bus.btn_press;
      disp_mag_q  <= '0;
      disp_neg_q  <= 1'b0;
      disp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_cnt_q     <= a_cnt_d;
      b_cnt_q     <= b_cnt_d;
      op_q        <= op_d;
      btn_press_q <= bus.btn_press;
      disp_mag_q  <= disp_mag_d;
      disp_neg_q  <= disp_neg_d;
      disp_err_q  <= disp_err_d;
    end
  end

  assign bus.disp_mag = disp_mag_q;
  assign bus.disp_neg = disp_neg_q;
  assign bus.disp_err = disp_err_q;
  assign bus.cur_op   = op_q;
  assign bus.state_o  = state_q;

endmodule
